// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: result/tag widths, functional-unit count and FU index encoding.
package tomasulo_pkg;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;
    localparam int NUM_FU = 4;

    typedef enum logic [1:0] {
        FU_ADD = 2'd0,
        FU_MUL = 2'd1,
        FU_LD  = 2'd2,
        FU_ST  = 2'd3
    } fu_idx_e;

    // Pointer starts at the last FU so the first search begins at FU_ADD.
    localparam logic [1:0] PTR_RESET = FU_ST;

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: searches from (ptr+1) mod 4 upward with wrap.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        any     = 1'b0;
        idx     = ptr;
        // Offset 4 wraps back to ptr itself, so the last-granted FU is tried last.
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among four FUs, one-cycle registered broadcast.
module cdb_arbiter
    import tomasulo_pkg::*;
#(
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int TAG_W  = tomasulo_pkg::TAG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_FU-1:0]    req_valid,
    input  logic [4*TAG_W-1:0]   req_tag,
    input  logic [4*DATA_W-1:0]  req_data,
    output logic [NUM_FU-1:0]    req_ack,
    output logic                 cdb_valid,
    output logic [1:0]           cdb_sel,
    output logic [TAG_W-1:0]     cdb_tag,
    output logic [DATA_W-1:0]    cdb_data,
    output logic [15:0]          bcast_cnt
);

    // Handshake: an FU raises req_valid with tag/data and holds all three stable
    // until it sees req_ack high in the same cycle; the ack edge is the transfer,
    // and the broadcast appears on the CDB registers one cycle later.

    logic [1:0]        ptr_q, ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [1:0]        cdb_sel_q, cdb_sel_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [15:0]       bcast_cnt_q, bcast_cnt_d;

    logic [3:0] pick_gnt;
    logic [1:0] pick_idx;
    logic       pick_any;
    logic       grant_en;

    rr_pick4 u_pick (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign grant_en = pick_any && !flush && !rst;
    assign req_ack  = grant_en ? pick_gnt : 4'b0000;

    always_comb begin
        ptr_d       = ptr_q;
        cdb_valid_d = 1'b0;
        cdb_sel_d   = cdb_sel_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        bcast_cnt_d = bcast_cnt_q;
        if (grant_en) begin
            ptr_d       = pick_idx;
            cdb_valid_d = 1'b1;
            cdb_sel_d   = pick_idx;
            for (int i = 0; i < 4; i++) begin
                if (pick_idx == 2'(i)) begin
                    cdb_tag_d  = req_tag[i*TAG_W +: TAG_W];
                    cdb_data_d = req_data[i*DATA_W +: DATA_W];
                end
            end
            if (bcast_cnt_q != 16'hFFFF) begin
                bcast_cnt_d = bcast_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= PTR_RESET;
            cdb_valid_q <= 1'b0;
            cdb_sel_q   <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            bcast_cnt_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_sel_q   <= cdb_sel_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            bcast_cnt_q <= bcast_cnt_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_sel   = cdb_sel_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign bcast_cnt = bcast_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic [3:0]           req_valid;
    logic [4*TAG_W-1:0]   req_tag;
    logic [4*DATA_W-1:0]  req_data;
    logic [3:0]           req_ack;
    logic                 cdb_valid;
    logic [1:0]           cdb_sel;
    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic [15:0]          bcast_cnt;

    int checks   = 0;
    int failures = 0;

    logic [TAG_W-1:0]  exp_tag  [4];
    logic [DATA_W-1:0] exp_data [4];
    logic [1:0]        exp_q[$];
    logic [1:0]        exp_sel;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .cdb_valid (cdb_valid),
        .cdb_sel   (cdb_sel),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .bcast_cnt (bcast_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive_req(input logic [3:0] v, input logic f);
        req_valid = v;
        flush     = f;
        #1;
    endtask

    task automatic load_payload();
        exp_tag  = '{4'h5, 4'h6, 4'h7, 4'h8};
        exp_data = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333};
        for (int i = 0; i < 4; i++) begin
            req_tag[i*TAG_W +: TAG_W]    = exp_tag[i];
            req_data[i*DATA_W +: DATA_W] = exp_data[i];
        end
    endtask

    task automatic check_bcast(input string name, input logic [1:0] sel);
        check({name, "_valid"}, 64'(cdb_valid), 64'd1);
        check({name, "_sel"},   64'(cdb_sel),   64'(sel));
        check({name, "_tag"},   64'(cdb_tag),   64'(exp_tag[sel]));
        check({name, "_data"},  64'(cdb_data),  64'(exp_data[sel]));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        req_valid = 4'b0000;
        req_tag = '0;
        req_data = '0;
        load_payload();

        // Reset with requests pending: no acks, all outputs cleared.
        tick();
        drive_req(4'b1111, 1'b0);
        check("rst_ack", 64'(req_ack), 64'd0);
        tick();
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_sel",   64'(cdb_sel),   64'd0);
        check("rst_tag",   64'(cdb_tag),   64'd0);
        check("rst_data",  64'(cdb_data),  64'd0);
        check("rst_cnt",   64'(bcast_cnt), 64'd0);
        rst = 1'b0;

        // All four valid for four cycles: grants 0,1,2,3.
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_ack", 64'(req_ack), 64'(4'b0001 << i));
            exp_q.push_back(2'(i));
            tick();
            exp_sel = exp_q.pop_front();
            check_bcast("rr", exp_sel);
        end
        drive_req(4'b0000, 1'b0);
        check("rr_cnt",      64'(bcast_cnt), 64'd4);
        check("idle_ack",    64'(req_ack),   64'd0);
        tick();
        check("idle_valid",  64'(cdb_valid), 64'd0);
        check("idle_hold_sel",  64'(cdb_sel),  64'd3);
        check("idle_hold_data", 64'(cdb_data), 64'hD3D3_3333);

        // Only FU2 valid with its own payload.
        req_tag[2*TAG_W +: TAG_W]    = 4'hA;
        req_data[2*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
        exp_tag[2]  = 4'hA;
        exp_data[2] = 32'hDEAD_BEEF;
        drive_req(4'b0100, 1'b0);
        check("fu2_ack", 64'(req_ack), 64'b0100);
        tick();
        check_bcast("fu2", 2'd2);
        check("fu2_cnt", 64'(bcast_cnt), 64'd5);

        // FU3 granted, then 1001 -> wrap to FU0, then FU3, then FU0.
        drive_req(4'b1000, 1'b0);
        check("fu3_ack", 64'(req_ack), 64'b1000);
        tick();
        check_bcast("fu3", 2'd3);
        drive_req(4'b1001, 1'b0);
        check("wrap0_ack", 64'(req_ack), 64'b0001);
        tick();
        check_bcast("wrap0", 2'd0);
        check("wrap3_ack", 64'(req_ack), 64'b1000);
        tick();
        check_bcast("wrap3", 2'd3);
        check("wrap0b_ack", 64'(req_ack), 64'b0001);
        tick();
        check_bcast("wrap0b", 2'd0);
        check("wrap_cnt", 64'(bcast_cnt), 64'd9);

        // Flush with 0011 pending; the registered broadcast from FU0 still shows.
        drive_req(4'b0011, 1'b1);
        check("flush_ack",        64'(req_ack),   64'd0);
        check("flush_prior_valid", 64'(cdb_valid), 64'd1);
        tick();
        check("flush_next_valid", 64'(cdb_valid), 64'd0);
        check("flush_cnt",        64'(bcast_cnt), 64'd9);
        drive_req(4'b0011, 1'b0);
        check("post_flush_ack", 64'(req_ack), 64'b0010);
        tick();
        check_bcast("post_flush", 2'd1);

        // Reset right after the FU1 grant with everything requesting.
        rst = 1'b1;
        drive_req(4'b1111, 1'b0);
        check("mid_rst_ack", 64'(req_ack), 64'd0);
        tick();
        check("mid_rst_valid", 64'(cdb_valid), 64'd0);
        check("mid_rst_sel",   64'(cdb_sel),   64'd0);
        check("mid_rst_tag",   64'(cdb_tag),   64'd0);
        check("mid_rst_data",  64'(cdb_data),  64'd0);
        check("mid_rst_cnt",   64'(bcast_cnt), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ack", 64'(req_ack), 64'b0001);
        tick();
        check_bcast("post_rst", 2'd0);
        check("post_rst_cnt", 64'(bcast_cnt), 64'd1);

        // Continuous grants up to the saturation boundary.
        repeat (65533) tick();
        check("sat_fffe", 64'(bcast_cnt), 64'hFFFE);
        tick();
        check("sat_ffff", 64'(bcast_cnt), 64'hFFFF);
        tick();
        tick();
        check("sat_hold", 64'(bcast_cnt), 64'hFFFF);
        check("sat_valid", 64'(cdb_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of the result value broadcast on the common data bus.
REQ-002 Parameter TAG_W, default 4, width of the reservation-station tag.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  squash the current grant and the next broadcast (branch mispredict).
REQ-007 req_valid  input  4  per-FU result-ready; FU0..FU3.
REQ-008 req_tag  input  4*TAG_W  packed tags; FUi occupies bits [i*TAG_W +: TAG_W].
REQ-009 req_data  input  4*DATA_W  packed results; FUi occupies bits [i*DATA_W +: DATA_W].
REQ-010 req_ack  output  4  one-hot grant; combinational, same cycle as the request.
REQ-011 cdb_valid  output  1  registered broadcast-valid.
REQ-012 cdb_sel  output  2  registered index of the broadcasting FU; drives the downstream 4:1 select muxes.
REQ-013 cdb_tag  output  TAG_W  registered broadcast tag.
REQ-014 cdb_data  output  DATA_W  registered broadcast value.
REQ-015 bcast_cnt  output  16  saturating count of broadcasts since reset.

Function
REQ-016 Each cycle, at most one req_ack bit SHALL be high, and only for a requester with req_valid=1.
REQ-017 Priority SHALL be round-robin: search starts at index (ptr+1) mod 4 and wraps, where ptr is the last-granted index.
REQ-018 A requester SHALL hold its req_valid, req_tag and req_data stable until it sees its req_ack; the arbiter does not latch requests that were not granted.
REQ-019 On a grant to FUi at edge N, cycle N+1 SHALL show cdb_valid=1, cdb_sel=i, cdb_tag=req_tag[i], cdb_data=req_data[i]. Latency is 1 cycle.
REQ-020 On a grant, ptr SHALL update to i at that edge.
REQ-021 With no req_valid bit set, req_ack=0, the next cdb_valid=0, and ptr is unchanged.
REQ-022 When cdb_valid=0, cdb_sel, cdb_tag and cdb_data SHALL hold their previous values.
REQ-023 While flush=1, req_ack SHALL be 0, the next cdb_valid SHALL be 0, and ptr and bcast_cnt are unchanged.
REQ-024 A flush SHALL NOT cancel a broadcast that is already registered; cdb_valid in the flush cycle reflects the prior grant.
REQ-025 bcast_cnt SHALL increment by 1 on each edge where a grant is made, and saturate at 16'hFFFF.
REQ-026 No requester SHALL wait more than 3 granted cycles while continuously valid, which gives starvation freedom.

Reset
REQ-027 On clk edge with rst=1, the block SHALL reset: cdb_valid=0, cdb_sel=0, cdb_tag=0, cdb_data=0, bcast_cnt=0, ptr=3, so FU0 has first priority.
REQ-028 During rst=1, req_ack SHALL be 0.
REQ-029 rst SHALL take precedence over flush and over requests.
REQ-030 A reset mid-operation SHALL discard any pending grant without a broadcast.

Structure
REQ-031 The shared package tomasulo_pkg SHALL hold DATA_W, TAG_W, NUM_FU=4 and the FU index encoding (FU_ADD=0, FU_MUL=1, FU_LD=2, FU_ST=3).
REQ-032 The round-robin pick SHALL be a combinational sub-module rr_pick4 (inputs req[3:0], ptr[1:0]; outputs gnt[3:0], gnt_idx[1:0], any).
REQ-033 All state SHALL be in cdb_arbiter: ptr, the CDB registers and bcast_cnt.

Verification
REQ-034 Reset, then req_valid=4'b1111 held for 4 cycles -> grants in the order 0,1,2,3; cdb_sel is 0,1,2,3 one cycle later; bcast_cnt=4.
REQ-035 Only FU2 valid, tag=4'hA, data=32'hDEADBEEF -> req_ack=4'b0100 in the same cycle; the next cycle gives cdb_valid=1, cdb_sel=2, cdb_tag=A, cdb_data=DEADBEEF.
REQ-036 FU3 granted last, then req_valid=4'b1001 -> FU0 granted (wrap-around), then FU3.
REQ-037 req_valid=4'b0011 with flush=1 for one cycle -> req_ack=0, next cdb_valid=0, ptr unchanged; the following cycle FU per the prior ptr is granted.
REQ-038 Grant to FU1, then rst=1 asserted in the next cycle -> all outputs return to 0, and after release FU0 wins against 4'b1111.
REQ-039 Force bcast_cnt to 16'hFFFE, then make 3 grants -> count reads FFFF and stays there.
